mac_pe_pipe: RTL and testbench

Parametrised signed multiply-accumulate processing element for the output-stationary FFN systolic array. It is the successor to the single-cycle MAC PE and adds:
- configurable multiplier pipeline depth
- per-beat valid and clear qualification
- saturating or wrapping accumulation with sticky overflow
- a drain shift chain that moves finished partial sums out along a PE row while the next dot product accumulates

Operands are forwarded east and south with one-cycle latency for array tiling.

---
 rtl/mac_pe_pipe.sv | 137 +++++++++++++
 tb/tb_mac_pe_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_pipe.sv
// Signed multiply-accumulate PE for the output-stationary systolic array:
// pipelined product, saturating/wrapping accumulate and a drain shift chain.
module mac_pe_pipe #(
    parameter int INPUT_WIDTH = 9,
    parameter int ACC_WIDTH   = 17,
    parameter int MUL_STAGES  = 1,
    parameter int SATURATE    = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_i,
    input  logic                   clear_i,
    input  logic [INPUT_WIDTH-1:0] data_a_i,
    input  logic [INPUT_WIDTH-1:0] data_b_i,
    output logic [INPUT_WIDTH-1:0] data_a_o,
    output logic [INPUT_WIDTH-1:0] data_b_o,
    output logic                   valid_o,
    output logic                   clear_o,
    input  logic                   drain_i,
    input  logic                   shift_i,
    input  logic [ACC_WIDTH-1:0]   psum_i,
    output logic [ACC_WIDTH-1:0]   psum_o,
    output logic [ACC_WIDTH-1:0]   acc_o,
    output logic                   ovf_o,
    output logic                   busy_o
);

    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;
    localparam int SUM_WIDTH  = ((ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH) + 1;
    localparam int TOP_WIDTH  = SUM_WIDTH - ACC_WIDTH + 1;

    logic [INPUT_WIDTH-1:0]        fwd_a_q, fwd_b_q;
    logic                          fwd_vld_q, fwd_clr_q;
    logic signed [PROD_WIDTH-1:0]  prod_d [MUL_STAGES];
    logic signed [PROD_WIDTH-1:0]  prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]         pvld_d, pvld_q, pclr_d, pclr_q;
    logic                          busy_d, busy_q;
    logic signed [ACC_WIDTH-1:0]   acc_d, acc_q;
    logic                          ovf_d, ovf_q;
    logic [ACC_WIDTH-1:0]          psum_d, psum_q;

    logic signed [SUM_WIDTH-1:0]   base_w, addend_w, sum_w;
    logic [TOP_WIDTH-1:0]          sum_top;
    logic                          out_of_range;
    logic                          out_vld, out_clr;
    logic signed [ACC_WIDTH-1:0]   limit_w;

    always_comb begin
        prod_d[0] = PROD_WIDTH'($signed(data_a_i)) * PROD_WIDTH'($signed(data_b_i));
        pvld_d[0] = valid_i;
        pclr_d[0] = clear_i;
        for (int i = 1; i < MUL_STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
            pvld_d[i] = pvld_q[i-1];
            pclr_d[i] = pclr_q[i-1];
        end
        busy_d = |pvld_d;
    end

    assign out_vld = pvld_q[MUL_STAGES-1];
    assign out_clr = pclr_q[MUL_STAGES-1];

    // Sum is formed one bit wider than either operand so it can never wrap
    // before the range check looks at it.
    always_comb begin
        // NOTE: each always_comb output is given a default up front, so no path leaves it unassigned and no latch is inferred.
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        addend_w = SUM_WIDTH'(prod_q[MUL_STAGES-1]);
        base_w   = out_clr ? '0 : SUM_WIDTH'(acc_q);
        sum_w    = base_w + addend_w;
        sum_top  = sum_w[SUM_WIDTH-1:ACC_WIDTH-1];
        out_of_range = !((&sum_top) || (~|sum_top));
        limit_w  = sum_w[SUM_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        if (out_vld) begin
            acc_d = (out_of_range && SATURATE != 0) ? limit_w : sum_w[ACC_WIDTH-1:0];
            ovf_d = out_clr ? out_of_range : (ovf_q | out_of_range);
        end else if (out_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Drain samples the accumulator before this edge's update, so a clear
    // arriving on the same edge hands the finished sum downstream intact.
    always_comb begin
        psum_d = psum_q;
        if (drain_i) begin
            psum_d = acc_q;
        end else if (shift_i) begin
            psum_d = psum_i;
        end
    end

    // NOTE: all state is written with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_a_q   <= '0;
            fwd_b_q   <= '0;
            fwd_vld_q <= 1'b0;
            fwd_clr_q <= 1'b0;
            // NOTE: the product stages are a handful of flops, not a RAM, so they are reset with everything else to discard in-flight beats.
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            pvld_q    <= '0;
            pclr_q    <= '0;
            busy_q    <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            psum_q    <= '0;
        end else begin
            fwd_a_q   <= data_a_i;
            fwd_b_q   <= data_b_i;
            fwd_vld_q <= valid_i;
            fwd_clr_q <= clear_i;
            prod_q    <= prod_d;
            pvld_q    <= pvld_d;
            pclr_q    <= pclr_d;
            busy_q    <= busy_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            psum_q    <= psum_d;
        end
    end

    assign data_a_o = fwd_a_q;
    assign data_b_o = fwd_b_q;
    assign valid_o  = fwd_vld_q;
    assign clear_o  = fwd_clr_q;
    assign acc_o    = acc_q;
    assign ovf_o    = ovf_q;
    assign psum_o   = psum_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mac_pe_pipe.sv
// Scoreboard bench for mac_pe_pipe: six PEs (saturating, wrapping, 3-stage,
// and a three-PE drain chain) driven by directed vectors.
module tb_mac_pe_pipe;

    localparam int N = 6;
    localparam int S_ACC = 0, S_OVF = 1, S_PSUM = 2, S_BUSY = 3,
                   S_A = 4, S_B = 5, S_VO = 6, S_CO = 7;

    typedef struct {
        int    due;
        int    sel;
        int    dut;
        int    exp;
        string name;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        vld_in [N];
    logic        clr_in [N];
    logic        drn    [N];
    logic        shf    [N];
    logic [8:0]  a_in   [N];
    logic [8:0]  b_in   [N];
    logic [8:0]  a_out  [N];
    logic [8:0]  b_out  [N];
    logic        vld_out[N];
    logic        clr_out[N];
    logic [16:0] psum_in [N];
    logic [16:0] psum_out[N];
    logic [16:0] acc    [N];
    logic        ovf    [N];
    logic        busy   [N];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // PE1 wraps, PE2 has a 3-deep product pipe, PE3->PE4->PE5 form a drain chain.
    for (genvar g = 0; g < N; g++) begin : g_pe
        if (g >= 4) begin : g_chain
            assign psum_in[g] = psum_out[g-1];
        end else begin : g_head
            assign psum_in[g] = '0;
        end
        mac_pe_pipe #(
            .INPUT_WIDTH(9),
            .ACC_WIDTH  (17),
            .MUL_STAGES ((g == 2) ? 3 : 1),
            .SATURATE   ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .valid_i (vld_in[g]),
            .clear_i (clr_in[g]),
            .data_a_i(a_in[g]),
            .data_b_i(b_in[g]),
            .data_a_o(a_out[g]),
            .data_b_o(b_out[g]),
            .valid_o (vld_out[g]),
            .clear_o (clr_out[g]),
            .drain_i (drn[g]),
            .shift_i (shf[g]),
            .psum_i  (psum_in[g]),
            .psum_o  (psum_out[g]),
            .acc_o   (acc[g]),
            .ovf_o   (ovf[g]),
            .busy_o  (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic signed [31:0] get_sig(int sel, int d);
        case (sel)
            S_ACC:  return 32'($signed(acc[d]));
            S_OVF:  return 32'(ovf[d]);
            S_PSUM: return 32'($signed(psum_out[d]));
            S_BUSY: return 32'(busy[d]);
            S_A:    return 32'($signed(a_out[d]));
            S_B:    return 32'($signed(b_out[d]));
            S_VO:   return 32'(vld_out[d]);
            S_CO:   return 32'(clr_out[d]);
            default: return 'x;
        endcase
    endfunction

    // Expected value becomes due 'delay' negedges from now.
    task automatic push(int delay, int sel, int d, int exp, string name);
        exp_t e;
        e.due  = cyc + delay;
        e.sel  = sel;
        e.dut  = d;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) begin
                check(sb[i].name, get_sig(sb[i].sel, sb[i].dut), sb[i].exp);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic beat(int d, bit v, bit c, int a, int b);
        vld_in[d] = v;
        clr_in[d] = c;
        a_in[d]   = 9'(a);
        b_in[d]   = 9'(b);
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            vld_in[i] = 1'b0;
            clr_in[i] = 1'b0;
            drn[i]    = 1'b0;
            shf[i]    = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        rstn = 1'b0;
        idle_all();
        for (int i = 0; i < N; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_acc%0d", i), get_sig(S_ACC, i), 0);
            check($sformatf("rst_busy%0d", i), get_sig(S_BUSY, i), 0);
        end

        // Forwarding is unconditional, independent of valid_i.
        beat(0, 0, 1, 5, -7);
        push(1, S_A, 0, 5, "fwd_a");
        push(1, S_B, 0, -7, "fwd_b");
        push(1, S_VO, 0, 0, "fwd_valid");
        push(1, S_CO, 0, 1, "fwd_clear");
        cycle();
        cycle();

        // Reset with two beats in flight in the 3-stage PE.
        beat(2, 1, 1, 7, -3);
        cycle();
        beat(2, 1, 0, 1, 1);
        cycle();
        rstn = 1'b0;
        #1;
        check("midrst_acc", get_sig(S_ACC, 2), 0);
        check("midrst_busy", get_sig(S_BUSY, 2), 0);
        check("midrst_a", get_sig(S_A, 2), 0);
        check("midrst_valid", get_sig(S_VO, 2), 0);
        check("midrst_psum", get_sig(S_PSUM, 2), 0);
        check("midrst_ovf", get_sig(S_OVF, 2), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) cycle();
        check("postrst_acc", get_sig(S_ACC, 2), 0);
        check("postrst_busy", get_sig(S_BUSY, 2), 0);

        // Basic dot product, one product stage.
        beat(0, 1, 1, -2, 2);  push(2, S_ACC, 0, -4, "dot0");  cycle();
        beat(0, 1, 0, 1, 2);   push(2, S_ACC, 0, -2, "dot1");  cycle();
        beat(0, 1, 0, 2, -3);  push(2, S_ACC, 0, -8, "dot2");  cycle();
        beat(0, 1, 0, 3, 1);   push(2, S_ACC, 0, -5, "dot3");
        push(2, S_OVF, 0, 0, "dot_ovf");
        push(1, S_BUSY, 0, 1, "dot_busy_hi");
        push(2, S_BUSY, 0, 0, "dot_busy_lo");
        cycle();
        cycle();

        // Saturation.
        beat(0, 1, 1, 255, 255);   push(2, S_ACC, 0, 65025, "sat0");
        push(2, S_OVF, 0, 0, "sat0_ovf");                   cycle();
        beat(0, 1, 0, 255, 255);   push(2, S_ACC, 0, 65535, "sat1");
        push(2, S_OVF, 0, 1, "sat1_ovf");                   cycle();
        beat(0, 0, 1, 0, 0);       push(2, S_ACC, 0, 0, "sat_clr");
        push(2, S_OVF, 0, 0, "sat_clr_ovf");                cycle();
        beat(0, 1, 1, -256, -256); push(2, S_ACC, 0, 65535, "sat_neg");
        push(2, S_OVF, 0, 1, "sat_neg_ovf");                cycle();
        cycle();

        // Wrapping.
        beat(1, 1, 1, 255, 255);   push(2, S_ACC, 1, 65025, "wrap0");  cycle();
        beat(1, 1, 0, 255, 255);   push(2, S_ACC, 1, -1022, "wrap1");
        push(2, S_OVF, 1, 1, "wrap1_ovf");                             cycle();
        beat(1, 1, 1, 1, 1);       push(2, S_ACC, 1, 1, "wrap_clr");
        push(2, S_OVF, 1, 0, "wrap_clr_ovf");                          cycle();
        beat(1, 0, 1, 0, 0);       push(2, S_ACC, 1, 0, "wrap_zero");  cycle();
        cycle();

        // Three product stages.
        beat(2, 1, 1, 7, -3);
        push(3, S_ACC, 2, 0, "deep_early");
        push(4, S_ACC, 2, -21, "deep_first");
        cycle();
        beat(2, 0, 0, 9, 9);       push(4, S_ACC, 2, -21, "deep_gap");   cycle();
        beat(2, 1, 0, 2, 2);       push(4, S_ACC, 2, -17, "deep_acc");
        push(4, S_OVF, 2, 0, "deep_ovf");                               cycle();
        repeat (4) cycle();

        // Drain chain PE3 -> PE4 -> PE5.
        beat(3, 1, 1, 2, 5);
        beat(4, 1, 1, -4, 5);
        beat(5, 1, 1, 5, 6);
        cycle();
        beat(5, 1, 1, 3, 3);
        cycle();
        for (int i = 3; i < N; i++) drn[i] = 1'b1;
        beat(5, 1, 0, 1, 1);
        push(1, S_PSUM, 5, 30, "drain5");
        push(1, S_PSUM, 4, -20, "drain4");
        push(1, S_ACC, 5, 9, "drain_newclr");
        push(2, S_ACC, 5, 10, "drain_newacc");
        cycle();
        for (int i = 3; i < N; i++) shf[i] = 1'b1;
        push(1, S_PSUM, 5, -20, "shift1");
        cycle();
        for (int i = 3; i < N; i++) shf[i] = 1'b1;
        push(1, S_PSUM, 5, 10, "shift2");
        cycle();
        for (int i = 3; i < N; i++) shf[i] = 1'b1;
        push(1, S_PSUM, 5, 0, "shift3");
        cycle();
        drn[5] = 1'b1;
        shf[5] = 1'b1;
        push(1, S_PSUM, 5, 10, "drain_over_shift");
        cycle();

        repeat (3) cycle();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
